// File: rtl/bubsys_rom_loader_if.sv
// bubsys_rom_loader_if: hps_io ioctl byte stream plus the SDRAM word write port of the ROM loader
interface bubsys_rom_loader_if;
    logic [15:0] ioctl_index;
    logic        ioctl_download;
    logic [26:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        ioctl_wait;
    logic        o_SDRAM_WR_REQ;
    logic [21:0] o_SDRAM_WR_ADDR;
    logic [15:0] o_SDRAM_WR_DATA;
    logic [1:0]  o_SDRAM_WR_BE;
    logic        i_SDRAM_WR_ACK;
    modport master (
        output ioctl_index, ioctl_download, ioctl_addr, ioctl_data, ioctl_wr, i_SDRAM_WR_ACK,
        input  ioctl_wait, o_SDRAM_WR_REQ, o_SDRAM_WR_ADDR, o_SDRAM_WR_DATA, o_SDRAM_WR_BE
    );
    modport slave (
        input  ioctl_index, ioctl_download, ioctl_addr, ioctl_data, ioctl_wr, i_SDRAM_WR_ACK,
        output ioctl_wait, o_SDRAM_WR_REQ, o_SDRAM_WR_ADDR, o_SDRAM_WR_DATA, o_SDRAM_WR_BE
    );
endinterface

// File: rtl/bubsys_rom_loader.sv
// bubsys_rom_loader: packs ioctl bytes into big-endian SDRAM words; BUBSYS_LOADER_CHECKSUM_EN adds o_CHECKSUM
module bubsys_rom_loader #(
    parameter logic [15:0] ROM_INDEX = 16'd0,
    parameter logic [22:0] ROM_WORDS = 23'h100000
) (
    input  logic               i_EMU_MCLK,
    input  logic               i_EMU_SOFTRST,
    bubsys_rom_loader_if.slave bus,
    output logic               o_LOADING,
    output logic               o_LOAD_DONE,
    output logic               o_SEQ_ERR,
    output logic               o_OVF
`ifdef BUBSYS_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]        o_CHECKSUM
`endif
);
    typedef enum logic [2:0] {IDLE, EVEN, ODD, WRITE, FLUSH, DONE} state_t;
    state_t state, state_n;
    logic active, active_q, start, stop, hit, over;
    logic [22:0] wa, wa_n;
    logic [15:0] data, data_n;
    logic [1:0] be, be_n;
    logic seq_n, ovf_n;
    assign active = bus.ioctl_download & (bus.ioctl_index == ROM_INDEX);
    assign start = active & ~active_q;
    assign stop = ~active & active_q;
    assign hit = bus.ioctl_wr & active;
    assign over = bus.ioctl_addr >= {3'b000, ROM_WORDS, 1'b0};
    assign bus.o_SDRAM_WR_ADDR = wa[21:0];
    assign bus.o_SDRAM_WR_DATA = data;
    assign bus.o_SDRAM_WR_BE = be;
    always_comb begin
        state_n = state;
        wa_n = wa;
        data_n = data;
        be_n = be;
        seq_n = o_SEQ_ERR;
        ovf_n = o_OVF;
        case (state)
            IDLE: if (start) begin
                state_n = EVEN;
                seq_n = 1'b0;
                ovf_n = 1'b0;
            end
            EVEN: if (stop) state_n = DONE;
                else if (hit & over) ovf_n = 1'b1;
                else if (hit & bus.ioctl_addr[0]) seq_n = 1'b1;
                else if (hit) begin
                    wa_n = bus.ioctl_addr[23:1];
                    data_n[15:8] = bus.ioctl_data;
                    state_n = ODD;
                end
            // download ended mid-word: flush the lone high byte with the low lane masked
            ODD: if (stop) begin
                    data_n[7:0] = 8'h00;
                    be_n = 2'b10;
                    state_n = FLUSH;
                end
                else if (hit & over) ovf_n = 1'b1;
                else if (hit & bus.ioctl_addr[0] & (bus.ioctl_addr[23:1] == wa)) begin
                    data_n[7:0] = bus.ioctl_data;
                    be_n = 2'b11;
                    state_n = WRITE;
                end
                else if (hit) seq_n = 1'b1;
            WRITE: if (bus.i_SDRAM_WR_ACK) state_n = active ? EVEN : DONE;
            FLUSH: if (bus.i_SDRAM_WR_ACK) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_SOFTRST) begin
            state <= IDLE;
            active_q <= 1'b0;
            wa <= '0;
            data <= '0;
            be <= 2'b00;
            o_SEQ_ERR <= 1'b0;
            o_OVF <= 1'b0;
            bus.o_SDRAM_WR_REQ <= 1'b0;
            bus.ioctl_wait <= 1'b0;
            o_LOADING <= 1'b0;
            o_LOAD_DONE <= 1'b0;
        end else begin
            state <= state_n;
            // forgetting the level in DONE lets a download that rose during DONE start from IDLE
            active_q <= (state == DONE) ? 1'b0 : active;
            wa <= wa_n;
            data <= data_n;
            be <= be_n;
            o_SEQ_ERR <= seq_n;
            o_OVF <= ovf_n;
            bus.o_SDRAM_WR_REQ <= (state_n == WRITE) | (state_n == FLUSH);
            bus.ioctl_wait <= (state_n == WRITE) | (state_n == FLUSH);
            o_LOADING <= state_n != IDLE;
            o_LOAD_DONE <= state == DONE;
        end
    end
`ifdef BUBSYS_LOADER_CHECKSUM_EN
    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_SOFTRST) o_CHECKSUM <= '0;
        else if (state == IDLE && start) o_CHECKSUM <= '0;
        else if ((state == EVEN && state_n == ODD) || (state == ODD && state_n == WRITE))
            o_CHECKSUM <= o_CHECKSUM + {8'h00, bus.ioctl_data};
    end
`endif
endmodule

// File: tb/tb_bubsys_rom_loader.sv
// tb_bubsys_rom_loader: directed bench for the ROM loader with an auto-ACK responder and a write scoreboard
module tb_bubsys_rom_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    bubsys_rom_loader_if bus();
    logic loading, load_done, seq_err, ovf;
`ifdef BUBSYS_LOADER_CHECKSUM_EN
    logic [15:0] csum;
`endif
    logic auto_ack = 1'b0;
    logic man_ack = 1'b0;
    logic ack_en = 1'b1;
    int ack_delay = 1;
    int req_cnt = 0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_total = 0;
    int ack_cyc = 0;
    int fall_cyc = 0;
    typedef struct {
        logic [21:0] a;
        logic [15:0] d;
        logic [1:0]  be;
    } wr_t;
    wr_t sb[$];
    assign bus.i_SDRAM_WR_ACK = auto_ack | man_ack;

    bubsys_rom_loader #(.ROM_INDEX(16'd0), .ROM_WORDS(23'd4)) dut (
        .i_EMU_MCLK(clk),
        .i_EMU_SOFTRST(rst),
        .bus(bus),
        .o_LOADING(loading),
        .o_LOAD_DONE(load_done),
        .o_SEQ_ERR(seq_err),
        .o_OVF(ovf)
`ifdef BUBSYS_LOADER_CHECKSUM_EN
        ,
        .o_CHECKSUM(csum)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial forever @(posedge clk) cyc++;

    // ACK responder and scoreboard consumer: every acknowledged write must match the oldest expected word
    initial begin : mon
        wr_t e;
        forever begin
            @(negedge clk);
            auto_ack = 1'b0;
            if (!bus.o_SDRAM_WR_REQ) req_cnt = 0;
            else if (ack_en) begin
                req_cnt++;
                if (req_cnt > ack_delay) begin
                    auto_ack = 1'b1;
                    ack_cyc = cyc;
                    chk("sb_nonempty", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("wr_addr", bus.o_SDRAM_WR_ADDR, e.a);
                        chk("wr_data", bus.o_SDRAM_WR_DATA, e.d);
                        chk("wr_be", bus.o_SDRAM_WR_BE, e.be);
                    end
                end
            end
            if (load_done) done_total++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [26:0] a, input logic [7:0] d);
        int n = 0;
        while (bus.ioctl_wait && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_bound", n < 100, 1);
        bus.ioctl_addr = a;
        bus.ioctl_data = d;
        bus.ioctl_wr = 1'b1;
        @(negedge clk);
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic start_dl(input logic [15:0] idx);
        bus.ioctl_index = idx;
        bus.ioctl_download = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_dl;
        bus.ioctl_download = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic drain;
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_bound", n < 100, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done(input bit from_ack, input string tag);
        int n = 0;
        while (!load_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, cyc - (from_ack ? ack_cyc : fall_cyc), 2);
        @(negedge clk);
        chk("done_width", load_done, 0);
        chk("loading_after_done", loading, 0);
    endtask

    initial begin
        bus.ioctl_index = 16'd0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_addr = '0;
        bus.ioctl_data = '0;
        bus.ioctl_wr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wait", bus.ioctl_wait, 0);
        chk("rst_req", bus.o_SDRAM_WR_REQ, 0);
        chk("rst_addr", bus.o_SDRAM_WR_ADDR, 0);
        chk("rst_data", bus.o_SDRAM_WR_DATA, 0);
        chk("rst_be", bus.o_SDRAM_WR_BE, 0);
        chk("rst_loading", loading, 0);
        chk("rst_done", load_done, 0);
        chk("rst_seq", seq_err, 0);
        chk("rst_ovf", ovf, 0);
`ifdef BUBSYS_LOADER_CHECKSUM_EN
        chk("rst_csum", csum, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        // four aligned bytes, ACK two cycles after REQ
        ack_delay = 2;
        start_dl(16'd0);
        chk("t1_loading", loading, 1);
        sb.push_back('{22'd0, 16'h1234, 2'b11});
        sb.push_back('{22'd1, 16'h5678, 2'b11});
        send_byte(27'd0, 8'h12);
        send_byte(27'd1, 8'h34);
        send_byte(27'd2, 8'h56);
        send_byte(27'd3, 8'h78);
        drain;
        end_dl;
        wait_done(1'b0, "t1_done_latency");
        chk("t1_seq", seq_err, 0);
        chk("t1_ovf", ovf, 0);
        // odd byte count flushes a masked half-word
        ack_delay = 1;
        start_dl(16'd0);
        sb.push_back('{22'd0, 16'hAABB, 2'b11});
        sb.push_back('{22'd1, 16'hCC00, 2'b10});
        send_byte(27'd0, 8'hAA);
        send_byte(27'd1, 8'hBB);
        send_byte(27'd2, 8'hCC);
        end_dl;
        wait_done(1'b1, "t2_done_after_ack");
        chk("t2_drained", sb.size(), 0);
        // long ACK stall holds the request and stall stable
        ack_delay = 20;
        start_dl(16'd0);
        sb.push_back('{22'd0, 16'hC0DE, 2'b11});
        send_byte(27'd0, 8'hC0);
        send_byte(27'd1, 8'hDE);
        for (int i = 0; i < 18; i++) begin
            chk("t3_wait", bus.ioctl_wait, 1);
            chk("t3_req", bus.o_SDRAM_WR_REQ, 1);
            chk("t3_addr", bus.o_SDRAM_WR_ADDR, 0);
            chk("t3_data", bus.o_SDRAM_WR_DATA, 16'hC0DE);
            chk("t3_be", bus.o_SDRAM_WR_BE, 2'b11);
            @(negedge clk);
        end
        drain;
        end_dl;
        wait_done(1'b0, "t3_done_latency");
        // odd-addressed byte in EVEN is a sequence error
        ack_delay = 1;
        start_dl(16'd0);
        send_byte(27'd1, 8'h11);
        chk("t4_seq_set", seq_err, 1);
        chk("t4_no_req", bus.o_SDRAM_WR_REQ, 0);
        sb.push_back('{22'd1, 16'h2233, 2'b11});
        send_byte(27'd2, 8'h22);
        send_byte(27'd3, 8'h33);
        drain;
        end_dl;
        wait_done(1'b0, "t4_done_latency");
        chk("t4_seq_sticky", seq_err, 1);
        // capacity boundary, ACK in the first REQ cycle
        ack_delay = 0;
        start_dl(16'd0);
        chk("t5_seq_cleared", seq_err, 0);
        sb.push_back('{22'd3, 16'h6677, 2'b11});
        send_byte(27'd6, 8'h66);
        send_byte(27'd7, 8'h77);
        send_byte(27'd8, 8'h88);
        send_byte(27'd9, 8'h99);
        chk("t5_ovf", ovf, 1);
        chk("t5_seq", seq_err, 0);
        chk("t5_loading", loading, 1);
        drain;
        end_dl;
        wait_done(1'b0, "t5_done_latency");
        // foreign index is ignored
        start_dl(16'd5);
        send_byte(27'd0, 8'h5A);
        send_byte(27'd1, 8'hA5);
        chk("t6_loading", loading, 0);
        chk("t6_req", bus.o_SDRAM_WR_REQ, 0);
        bus.ioctl_download = 1'b0;
        @(negedge clk);
        // reset while a write is pending, then a late ACK
        ack_en = 1'b0;
        start_dl(16'd0);
        chk("t7_ovf_cleared", ovf, 0);
        send_byte(27'd0, 8'h01);
        send_byte(27'd1, 8'h02);
        chk("t7_req_up", bus.o_SDRAM_WR_REQ, 1);
        chk("t7_wait_up", bus.ioctl_wait, 1);
        rst = 1'b1;
        bus.ioctl_download = 1'b0;
        @(negedge clk);
        chk("t7_req_rst", bus.o_SDRAM_WR_REQ, 0);
        chk("t7_loading_rst", loading, 0);
        chk("t7_wait_rst", bus.ioctl_wait, 0);
        rst = 1'b0;
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        @(negedge clk);
        chk("t7_late_ack_req", bus.o_SDRAM_WR_REQ, 0);
        chk("t7_late_ack_loading", loading, 0);
        chk("t7_late_ack_done", load_done, 0);
        ack_en = 1'b1;
        // checksum image, also a second flush case
        ack_delay = 1;
        start_dl(16'd0);
        sb.push_back('{22'd0, 16'hFF02, 2'b11});
        sb.push_back('{22'd1, 16'h8000, 2'b10});
        send_byte(27'd0, 8'hFF);
        send_byte(27'd1, 8'h02);
        send_byte(27'd2, 8'h80);
        end_dl;
        wait_done(1'b1, "t8_done_after_ack");
`ifdef BUBSYS_LOADER_CHECKSUM_EN
        chk("t8_csum", csum, 16'h0181);
`endif
        chk("done_pulses", done_total, 6);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bubsys_rom_loader.md
# bubsys_rom_loader

Download-side stage between the HPS ioctl byte stream and the SDRAM write port of the Bubble System game board. It packs the ROM image's byte stream into big-endian 16-bit words for the 68000. It issues one SDRAM write request per word and throttles the HPS with `ioctl_wait` while a write is pending. It flushes a trailing odd byte as a masked half-word and reports completion, sequence errors and overflow.

## Interface
Parameters:
- `ROM_INDEX`, 16'd0: `ioctl_index` value that selects this loader; other indices are ignored.
- `ROM_WORDS`, 23'h100000: ROM capacity in 16-bit words. Bytes at addresses ≥ 2·ROM_WORDS are dropped.

Ports:
- `i_EMU_MCLK` in 1: the single clock (72 MHz domain shared with hps_io).
- `i_EMU_SOFTRST` in 1: reset, synchronous, active-high.
- `ioctl_index` in 16: download target index.
- `ioctl_download` in 1: high for the whole transfer.
- `ioctl_addr` in 27: byte address of `ioctl_data`.
- `ioctl_data` in 8: byte value.
- `ioctl_wr` in 1: one-cycle byte strobe.
- `ioctl_wait` out 1: stall request to hps_io.
- `o_SDRAM_WR_REQ` out 1: write request, held until acknowledged.
- `o_SDRAM_WR_ADDR` out 22: word address.
- `o_SDRAM_WR_DATA` out 16: data; the even byte is in [15:8].
- `o_SDRAM_WR_BE` out 2: byte enables, [1] = high byte.
- `i_SDRAM_WR_ACK` in 1: one-cycle acknowledge. Valid only while REQ is high.
- `o_LOADING` out 1: a ROM download is in progress.
- `o_LOAD_DONE` out 1: one-cycle pulse after the final write is acknowledged.
- `o_SEQ_ERR` out 1: sticky flag for a byte with unexpected parity. Cleared at download start.
- `o_OVF` out 1: sticky flag for a byte beyond capacity. Cleared at download start.
- `o_CHECKSUM` out 16: present only with the macro described under Configuration.

## Operation
- States: IDLE, EVEN, ODD, WRITE, FLUSH, DONE.
- An active download is `ioctl_download & (ioctl_index == ROM_INDEX)`.
- IDLE: on a rising edge of the active-download condition, clear the sticky flags and go to EVEN.
- EVEN, on an accepted `ioctl_wr` with `addr[0]=0`:
  - Latch the data into [15:8] and `addr[23:1]` into the word address.
  - Go to ODD.
  - If the byte has `addr[0]=1`, set SEQ_ERR and discard it.
- ODD, on an accepted `ioctl_wr`:
  - If `addr[0]=1` and `addr[23:1]` matches the latched address, latch the data into [7:0], set BE=2'b11 and go to WRITE.
  - Otherwise set SEQ_ERR and discard the byte.
- Overflow: a byte with `addr ≥ 2·ROM_WORDS` sets OVF, is discarded and causes no state change.
- WRITE: hold REQ, ADDR, DATA and BE stable until ACK. On ACK go to EVEN, or to DONE if the download has ended.
- Download end (active condition falls):
  - In EVEN, go to DONE.
  - In ODD, go to FLUSH with DATA[7:0]=0 and BE=2'b10.
  - In WRITE, complete the write, then go to DONE.
- FLUSH: same handshake as WRITE, then go to DONE.
- DONE: pulse LOAD_DONE for one cycle, then go to IDLE.
- `ioctl_wr` seen in WRITE, FLUSH, DONE or IDLE is ignored. hps_io honours `ioctl_wait`, so this occurs only on protocol violation.
- `o_LOADING` is high in every state except IDLE.

## Timing
- Reset values:
  - `ioctl_wait`, REQ, LOAD_DONE, SEQ_ERR, OVF and LOADING are 0.
  - ADDR, DATA and CHECKSUM are 0.
  - BE is 2'b00.
  - State is IDLE.
- Reset mid-transfer drops REQ on the next edge. A late ACK is then ignored.
- All outputs are registered.
- REQ and `ioctl_wait` rise together, on the clock edge after the odd byte's `ioctl_wr` cycle.
- Both fall on the edge after the ACK cycle.
- Minimum cost per word is 3 cycles when ACK arrives one cycle after REQ.
- ACK in the same cycle that REQ first rises is accepted.
- LOAD_DONE is high exactly one cycle, two edges after the final ACK. With no pending word, it is high two edges after download falls.
- A new download that starts during DONE is recognised in IDLE on the following cycle.

## Configuration
- `BUBSYS_LOADER_CHECKSUM_EN` defined:
  - `o_CHECKSUM` exists.
  - It holds the 16-bit wrap-around sum of every accepted byte.
  - The zero-padding byte of a flush is excluded.
  - It is cleared at download start and is stable from LOAD_DONE until the next start.
- Macro undefined: the port and its adder are absent. All other behaviour is identical.

## Test plan
- Four bytes 0x12,0x34,0x56,0x78 at addresses 0–3, ACK 2 cycles after REQ:
  - Two writes: addr 0 data 0x1234, then addr 1 data 0x5678, both BE=11.
  - One LOAD_DONE pulse; SEQ_ERR=0.
- Three bytes 0xAA,0xBB,0xCC, then download falls:
  - Writes 0xAABB@0, then 0xCC00@1 with BE=10.
  - LOAD_DONE two edges after the second ACK.
- ACK withheld for 20 cycles on the first word:
  - `ioctl_wait` stays high for the whole stall.
  - ADDR, DATA and BE do not change.
- Byte at addr 1 while in EVEN: SEQ_ERR=1, no write issued. The next pair at 2,3 writes to word 1.
- ROM_WORDS=4, bytes at addresses 6–9:
  - Word 3 is written.
  - Bytes 8 and 9 set OVF with no write.
- Reset asserted while REQ=1: REQ=0 and LOADING=0 on the next edge. An ACK the following cycle is ignored.
- With `BUBSYS_LOADER_CHECKSUM_EN` defined, bytes 0xFF,0x02,0x80 then download falls: CHECKSUM=0x0181.
